// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed, active-low 7-segment scan bus into three digits.
// A value is published only after MATCH_FRAMES identical, fully settled frames.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYC   = 4,
  parameter int unsigned MATCH_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg7_in,
  input  logic       seg7_dpt_in,
  input  logic [2:0] dig_sel,
  output logic [3:0] num2,
  output logic [3:0] num1,
  output logic [3:0] num0,
  output logic [2:0] dpt,
  output logic       valid,
  output logic       err
);

  localparam int unsigned CW = $clog2(STABLE_CYC + 1);
  localparam int unsigned MW = $clog2(MATCH_FRAMES + 1);
  localparam logic [CW:0]   STABLE_W = (CW + 1)'(STABLE_CYC);
  localparam logic [CW:0]   RUN_ONE  = (CW + 1)'(1);
  localparam logic [MW-1:0] MATCH_W  = MW'(MATCH_FRAMES);
  localparam logic [MW-1:0] MATCH_1  = MW'(1);

  typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

  state_t      state, state_n;
  logic [CW:0] cnt, cnt_n, run;
  logic        advance, capture;

  logic [6:0]  seg_r, seg_p;
  logic        dp_r, dp_p;
  logic [2:0]  sel_r, sel_p;
  logic        onehot, chg, sel_chg;

  logic [3:0]  dec_val;
  logic        dec_ill;

  logic [11:0]   sh_val, fr_val;
  logic [2:0]    sh_dp, fr_dp, sh_ill, fr_ill;
  logic [2:0]    mask, mask_n;
  logic [17:0]   frame, ref_frame;
  logic [MW-1:0] match_cnt, match_n;
  logic          complete, pend;

  // Input register plus one-cycle history used for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= '0;
      dp_r  <= 1'b0;
      sel_r <= '0;
      seg_p <= '0;
      dp_p  <= 1'b0;
      sel_p <= '0;
    end else begin
      seg_r <= seg7_in;
      dp_r  <= seg7_dpt_in;
      sel_r <= dig_sel;
      seg_p <= seg_r;
      dp_p  <= dp_r;
      sel_p <= sel_r;
    end
  end

  assign onehot  = (sel_r == 3'b001) || (sel_r == 3'b010) || (sel_r == 3'b100);
  assign chg     = {sel_r, seg_r, dp_r} != {sel_p, seg_p, dp_p};
  assign sel_chg = sel_r != sel_p;

  always_comb begin
    dec_val = 4'hF;
    dec_ill = 1'b0;
    case (seg_r)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      default:    dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // A strobe change out of HELD passes through WAIT within the same cycle and
  // counts as the first settled cycle, so back-to-back digits lose no cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    run     = RUN_ONE;
    advance = 1'b0;
    unique case (state)
      WAIT: advance = onehot;
      SETTLE: begin
        if (!onehot) begin
          state_n = WAIT;
          cnt_n   = '0;
        end else begin
          run     = chg ? RUN_ONE : cnt + RUN_ONE;
          advance = 1'b1;
        end
      end
      HELD: begin
        if (sel_chg) begin
          if (onehot) advance = 1'b1;
          else        state_n = WAIT;
        end
      end
      default: state_n = WAIT;
    endcase
    if (advance) begin
      if (run >= STABLE_W) begin
        state_n = HELD;
        cnt_n   = '0;
      end else begin
        state_n = SETTLE;
        cnt_n   = run;
      end
    end
  end

  always_comb begin
    capture = advance && (run >= STABLE_W);
  end

  always_comb begin
    fr_val = sh_val;
    fr_dp  = sh_dp;
    fr_ill = sh_ill;
    mask_n = mask;
    if (capture) begin
      mask_n = mask | sel_r;
      case (sel_r)
        3'b001: begin fr_val[3:0]  = dec_val; fr_dp[0] = ~dp_r; fr_ill[0] = dec_ill; end
        3'b010: begin fr_val[7:4]  = dec_val; fr_dp[1] = ~dp_r; fr_ill[1] = dec_ill; end
        3'b100: begin fr_val[11:8] = dec_val; fr_dp[2] = ~dp_r; fr_ill[2] = dec_ill; end
        default: ;
      endcase
    end
    complete = capture && (mask_n == 3'b111);
    frame    = {fr_val, fr_dp, fr_ill};
    if (frame == ref_frame)
      match_n = (match_cnt == MATCH_W) ? MATCH_W : match_cnt + MATCH_1;
    else
      match_n = MATCH_1;
  end

  // Publication lags frame completion by one cycle via pend
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_ill    <= '0;
      mask      <= '0;
      ref_frame <= '0;
      match_cnt <= '0;
      pend      <= 1'b0;
      num2      <= '0;
      num1      <= '0;
      num0      <= '0;
      dpt       <= '0;
      err       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      pend  <= 1'b0;
      if (capture) begin
        sh_val <= fr_val;
        sh_dp  <= fr_dp;
        sh_ill <= fr_ill;
        mask   <= complete ? 3'b000 : mask_n;
      end
      if (complete) begin
        ref_frame <= frame;
        match_cnt <= match_n;
        pend      <= (match_n == MATCH_W);
      end
      if (pend && (ref_frame[17:3] != {num2, num1, num0, dpt})) begin
        {num2, num1, num0, dpt} <= ref_frame[17:3];
        err   <= |ref_frame[2:0];
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized + directed bench: a step-level scan model feeds a scoreboard queue
// that a negedge monitor drains whenever valid pulses.
module tb_seg7_scan_decoder;

  localparam int unsigned S = 4;
  localparam int unsigned M = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg7_in = 7'h7F;
  logic       seg7_dpt_in = 1'b1;
  logic [2:0] dig_sel = 3'b000;
  logic [3:0] num2, num1, num0;
  logic [2:0] dpt;
  logic       valid, err;

  seg7_scan_decoder #(.STABLE_CYC(S), .MATCH_FRAMES(M)) dut (
    .clk(clk), .rst_n(rst_n), .seg7_in(seg7_in), .seg7_dpt_in(seg7_dpt_in),
    .dig_sel(dig_sel), .num2(num2), .num1(num1), .num0(num0),
    .dpt(dpt), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vcount = 0;
  int last_vcyc = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic [15:0] exp_q [$];

  // reference model state (scan-step level)
  logic [2:0]  m_prev_sel;
  bit          m_held;
  logic [11:0] m_fval;
  logic [2:0]  m_fdp, m_fill, m_mask;
  logic [17:0] m_ref;
  int          m_mc;
  logic [14:0] m_pub;
  logic [2:0]  last_sel = 3'b000;
  logic [6:0]  last_seg = 7'h7F;
  logic        last_dp = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && valid) begin
      vcount    = vcount + 1;
      last_vcyc = cyc;
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_valid: got %h%h%h dpt=%b err=%b, required no pulse",
                 num2, num1, num0, dpt, err);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({num2, num1, num0, dpt, err} !== e) begin
          n_bad = n_bad + 1;
          $display("FAIL publish: got %h%h%h dpt=%b err=%b, required %h%h%h dpt=%b err=%b",
                   num2, num1, num0, dpt, err, e[15:12], e[11:8], e[7:4], e[3:1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_prev_sel = '0; m_held = 0; m_fval = '0; m_fdp = '0; m_fill = '0;
    m_mask = '0; m_ref = '0; m_mc = 0; m_pub = '0;
  endtask

  task automatic model_step(input logic [2:0] sel, input logic [6:0] seg, input logic dp,
                            input int unsigned dur);
    bit oh, cap, same;
    int idx;
    logic [3:0] v;
    logic ill;
    logic [17:0] fr;
    oh   = $onehot(sel);
    same = (sel == m_prev_sel);
    cap  = oh && (dur >= S) && !(m_held && same);
    m_held = oh && (cap || (m_held && same));
    m_prev_sel = sel;
    if (!cap) return;
    idx = sel[0] ? 0 : (sel[1] ? 1 : 2);
    v = 4'hF; ill = 1'b1;
    for (int k = 0; k < 10; k++)
      if (seg == pat[k]) begin v = 4'(k); ill = 1'b0; end
    m_fval[idx*4 +: 4] = v;
    m_fdp[idx]  = ~dp;
    m_fill[idx] = ill;
    m_mask[idx] = 1'b1;
    if (m_mask == 3'b111) begin
      m_mask = '0;
      fr = {m_fval, m_fdp, m_fill};
      if (fr == m_ref) m_mc = (m_mc < int'(M)) ? m_mc + 1 : int'(M);
      else begin m_ref = fr; m_mc = 1; end
      if (m_mc == int'(M) && fr[17:3] != m_pub) begin
        m_pub = fr[17:3];
        exp_q.push_back({fr[17:3], |fr[2:0]});
      end
    end
  endtask

  task automatic drive_step(input logic [2:0] sel, input logic [6:0] seg, input logic dp,
                            input int unsigned dur);
    logic d;
    d = dp;
    if ({sel, seg, d} == {last_sel, last_seg, last_dp}) d = ~d;
    dig_sel = sel; seg7_in = seg; seg7_dpt_in = d;
    model_step(sel, seg, d, dur);
    last_sel = sel; last_seg = seg; last_dp = d;
    repeat (dur) begin @(posedge clk); #1; end
  endtask

  task automatic scan_frame(input int d2, input int d1, input int d0);
    drive_step(3'b100, pat[d2], 1'b1, S);
    drive_step(3'b010, pat[d1], 1'b1, S);
    drive_step(3'b001, pat[d0], 1'b1, S);
  endtask

  initial begin
    int v0, c0;
    logic [6:0] segs [3];
    logic dps [3];
    int reps;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {num2, num1, num0, dpt, valid, err}, 0);
    rst_n = 1'b1;
    drive_step(3'b000, 7'h7F, 1'b1, 2);

    // 4,0,0 twice: one pulse, latency 1 + M*3*S + 1
    v0 = vcount; c0 = cyc;
    scan_frame(4, 0, 0);
    scan_frame(4, 0, 0);
    drive_step(3'b000, 7'h7F, 1'b1, 6);
    check("s1_valid_count", vcount - v0, 1);
    check("s1_digits", {num2, num1, num0}, 12'h400);
    check("s1_err", err, 0);
    check("s1_latency", last_vcyc - c0, 1 + M * 3 * S + 1);

    // digit 1 held only S-1 cycles
    drive_step(3'b010, pat[1], 1'b1, S - 1);
    drive_step(3'b000, pat[1], 1'b1, 3);
    check("s2_mask", dut.mask, 3'b000);

    // A then B resets match count; second B publishes
    v0 = vcount;
    scan_frame(0, 3, 0);
    scan_frame(0, 0, 2);
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s3_match_cnt", dut.match_cnt, 1);
    check("s3_no_valid", vcount - v0, 0);
    scan_frame(0, 0, 2);
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s3_valid", vcount - v0, 1);
    check("s3_digits", {num2, num1, num0}, 12'h002);

    // illegal digit 0 then legal frames
    for (int r = 0; r < 2; r++) begin
      drive_step(3'b100, pat[5], 1'b1, S);
      drive_step(3'b010, pat[6], 1'b1, S);
      drive_step(3'b001, 7'b1111111, 1'b1, S);
    end
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s4_num0_illegal", num0, 4'hF);
    check("s4_err_set", err, 1);
    scan_frame(5, 6, 7);
    scan_frame(5, 6, 7);
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s4_err_clear", err, 0);
    check("s4_digits", {num2, num1, num0}, 12'h567);

    // two strobes at once never captures
    drive_step(3'b011, pat[8], 1'b1, 10);
    check("s5_state_wait", dut.state, 0);
    check("s5_mask", dut.mask, 3'b000);
    drive_step(3'b000, 7'h7F, 1'b1, 2);

    // reset after two captured digits
    drive_step(3'b100, pat[1], 1'b0, S);
    drive_step(3'b010, pat[2], 1'b1, S);
    drive_step(3'b000, 7'h7F, 1'b1, 2);
    #2 rst_n = 1'b0;
    #1 check("s6_async_reset", {num2, num1, num0, dpt, valid, err}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive_step(3'b000, 7'h7F, 1'b1, 2);
    v0 = vcount;
    drive_step(3'b001, pat[1], 1'b1, S);
    drive_step(3'b100, pat[8], 1'b1, S);
    drive_step(3'b010, pat[9], 1'b1, S);
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s6_one_frame_no_valid", vcount - v0, 0);
    drive_step(3'b001, pat[1], 1'b1, S);
    drive_step(3'b100, pat[8], 1'b1, S);
    drive_step(3'b010, pat[9], 1'b1, S);
    drive_step(3'b000, 7'h7F, 1'b1, 3);
    check("s6_valid", vcount - v0, 1);
    check("s6_digits", {num2, num1, num0}, 12'h891);

    // randomized frames with repeats, glitches and short strobes
    for (int g = 0; g < 60; g++) begin
      if (g % 5 != 0) begin
        for (int d = 0; d < 3; d++) begin
          segs[d] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)];
          dps[d]  = 1'($urandom_range(0, 1));
        end
      end
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        for (int d = 2; d >= 0; d--) begin
          if ($urandom_range(0, 9) == 0)
            drive_step(3'($urandom), 7'($urandom), 1'($urandom), $urandom_range(1, 3));
          drive_step(3'(1 << d), segs[d], dps[d], $urandom_range(S - 1, S + 2));
        end
      end
    end
    drive_step(3'b000, 7'h7F, 1'b1, 8);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
